fetch_pc_stage: RTL
===================

// Module: fetch_pc_stage
// PURPOSE
//  IF stage PC and IF/ID pipeline register of the DLX pipeline. Consumes the branch-resolution
//  'leap' flag and its target address, and owns the request/ack handshake to instruction memory.
//  Redirects the PC and flushes IF/ID on leap. Holds state under hazard stall, parking at most one
//  returned instruction in a skid buffer.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded by reset; must be word aligned
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous, active-low reset
//  leap         in   1     redirect request: taken branch or jump
//  leap_target  in   32    [0:31] redirect address; bits [30:31] forced to 0 on capture
//  stall        in   1     hazard stall: hold IF/ID contents and do not advance the PC
//  imem_req     out  1     instruction fetch request
//  imem_addr    out  32    [0:31] fetch address; equals the pc register
//  imem_ack     in   1     fetch complete when sampled high with imem_req=1; imem_data valid that cycle
//  imem_data    in   32    [0:31] returned instruction word
//  ifid_instr   out  32    [0:31] instruction presented to ID
//  ifid_pc4     out  32    [0:31] address of ifid_instr + 4
//  ifid_valid   out  1     ifid_instr is a real instruction (0 = bubble)
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC; ifid_instr=0, ifid_pc4=0, ifid_valid=0;
//    skid buffer=0, redir_pc=0; state=FETCH. imem_req=1 from the first clock after release.
//  - All outputs are registered or are direct decodes of state. imem_req=1 in FETCH and DRAIN,
//    0 in HOLD. imem_addr is stable while imem_req=1 and no ack has been received.
//  - FETCH:
//      - ack & !leap & !stall: ifid<={imem_data, pc+4, 1}; pc<=pc+4. One instruction per cycle at
//        zero wait states.
//      - !ack & !leap & !stall: ifid_valid<=0 (bubble); pc holds.
//      - stall & !leap: IF/ID holds. On ack: skid<=imem_data and go to HOLD; pc holds.
//      - leap & ack: discard imem_data; pc<=leap_target; ifid_valid<=0; stay in FETCH.
//      - leap & !ack: redir_pc<=leap_target; ifid_valid<=0; go to DRAIN. The outstanding request
//        stays at the old address.
//  - HOLD (imem_req=0):
//      - !stall & !leap: ifid<={skid, pc+4, 1}; pc<=pc+4; go to FETCH.
//      - leap: discard skid; pc<=leap_target; ifid_valid<=0; go to FETCH.
//  - DRAIN:
//      - Wait for ack; ifid_valid stays 0.
//      - On ack: discard imem_data; pc<=redir_pc; go to FETCH.
//      - A further leap in DRAIN overwrites redir_pc (latest target wins).
//      - If leap and ack fall in the same cycle, the new leap_target is loaded into pc directly.
//  - Priority: leap > stall > normal advance. A flush clears ifid_valid even while stall=1.
//  - Arithmetic: pc+4 is unsigned 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  - No PC value is ever skipped or duplicated except through leap redirection.
//  - rst_n assertion in any state returns everything to reset values immediately, including
//    mid-HOLD and mid-DRAIN. A pending ack is ignored.
// TESTING
//  1. Reset release, ack tied high, RESET_PC=0
//     -> imem_addr 0,4,8,C on successive cycles; ifid_pc4 4,8,C; ifid_valid=1 from cycle 2.
//  2. stall=1 for 3 cycles with ack during the first stall cycle
//     -> HOLD entered, imem_req=0, IF/ID unchanged.
//     -> On stall drop, skid word appears on ifid_instr the next cycle; pc advances by 4.
//  3. leap=1 with target 32'h0000_0103 in the same cycle as ack
//     -> next imem_addr=32'h0000_0100; ifid_valid=0 for that cycle.
//  4. leap target 0x200 while ack is delayed 3 cycles
//     -> imem_addr holds the old pc until ack; returned data never reaches IF/ID.
//     -> The cycle after ack, imem_addr=0x200.
//  5. pc=32'hFFFF_FFFC with ack -> ifid_pc4=0 and next imem_addr=0.
//  6. rst_n pulsed low mid-HOLD and mid-DRAIN
//     -> outputs reset asynchronously; fetch restarts at RESET_PC; stale ack ignored.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// IF-stage program counter, IF/ID pipeline register and instruction-memory handshake.
// Handles branch redirect (leap), hazard stall with a one-entry skid buffer, and redirect-while-busy drain.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        leap,
    input  logic [31:0] leap_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    // state | meaning
    // FETCH | request outstanding at pc, ack advances IF/ID
    // HOLD  | stalled with a returned word parked in the skid buffer, no request
    // DRAIN | leap arrived mid-request; wait for the stale ack, then jump to redir_pc
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_skid, w_skid_nxt;
    logic [31:0] r_redir_pc, w_redir_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    // Bus bit numbering [0:31] is MSB-first, so its bits 30:31 are the two LSBs here.
    assign w_target   = leap_target & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_skid_nxt  = r_skid;
        w_redir_nxt = r_redir_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        case (r_state)
            S_FETCH: begin
                if (leap) begin
                    w_valid_nxt = 1'b0;
                    if (imem_ack) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_nxt = w_target;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        w_skid_nxt  = imem_data;
                        w_state_nxt = S_HOLD;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt = imem_data;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                if (leap) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_instr_nxt = r_skid;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                w_valid_nxt = 1'b0;
                if (imem_ack) begin
                    // A leap coinciding with the stale ack is newer than redir_pc.
                    w_pc_nxt    = leap ? w_target : r_redir_pc;
                    w_state_nxt = S_FETCH;
                end else if (leap) begin
                    w_redir_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_skid     <= 32'h0;
            r_redir_pc <= 32'h0;
            r_instr    <= 32'h0;
            r_pc4      <= 32'h0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_skid     <= w_skid_nxt;
            r_redir_pc <= w_redir_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign imem_req   = (r_state != S_HOLD);
    assign imem_addr  = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc4   = r_pc4;
    assign ifid_valid = r_valid;

endmodule
